// File: rtl/operand_loader_if.sv
// Operand-entry bus between the button/switch front end and the operand loader.
// The loader uses the master modport; the environment that feeds it uses slave.
interface operand_loader_if #(
    parameter int DATA_W = 16
);
    logic                  IN_STROBE;
    logic [DATA_W-1:0]     DATA_IN;
    logic                  OP_ACK;
    logic [2*DATA_W-1:0]   OP_A;
    logic [2*DATA_W-1:0]   OP_B;
    logic                  OP_VALID;
    logic [1:0]            WORD_IDX;
    logic                  BUSY;
    logic [1:0]            ERR;

    modport master (
        input  IN_STROBE, DATA_IN, OP_ACK,
        output OP_A, OP_B, OP_VALID, WORD_IDX, BUSY, ERR
    );

    modport slave (
        output IN_STROBE, DATA_IN, OP_ACK,
        input  OP_A, OP_B, OP_VALID, WORD_IDX, BUSY, ERR
    );
endinterface

// File: rtl/operand_loader.sv
// Assembles two single-precision operands from four switch words (high half first),
// flags NaN/Inf operands and hands the pair to the FP core with a valid/ack handshake.
module operand_loader #(
    parameter int DATA_W        = 16,
    parameter bit CHECK_SPECIAL = 1'b1
) (
    input logic              CLK,
    input logic              RESET,
    operand_loader_if.master bus
);
    localparam int OP_W    = 2 * DATA_W;
    localparam int EXP_MSB = OP_W - 2;
    localparam int EXP_LSB = OP_W - 9;

    typedef enum logic [2:0] {
        S_A_HI,
        S_A_LO,
        S_B_HI,
        S_B_LO,
        S_CHECK,
        S_VALID,
        S_ERROR
    } state_t;

    state_t            state;
    logic              strobe_q;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic              op_valid;
    logic [1:0]        word_idx;
    logic              busy;
    logic [1:0]        err;

    logic              accept;
    logic              a_bad;
    logic              b_bad;

    // The edge detector runs in every state, so a strobe still held when entry
    // restarts is not mistaken for a fresh press.
    assign accept = bus.IN_STROBE && !strobe_q;

    assign a_bad = (CHECK_SPECIAL == 1'b1) && (&op_a[EXP_MSB:EXP_LSB]);
    assign b_bad = (CHECK_SPECIAL == 1'b1) && (&op_b[EXP_MSB:EXP_LSB]);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the values from before the clock edge, independent of
    // statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_A_HI;
            strobe_q <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
            word_idx <= 2'd0;
            busy     <= 1'b0;
            err      <= 2'b00;
        end else begin
            strobe_q <= bus.IN_STROBE;

            case (state)
                S_A_HI: begin
                    if (accept) begin
                        op_a[OP_W-1:DATA_W] <= bus.DATA_IN;
                        word_idx            <= 2'd1;
                        state               <= S_A_LO;
                    end
                end

                S_A_LO: begin
                    if (accept) begin
                        op_a[DATA_W-1:0] <= bus.DATA_IN;
                        word_idx         <= 2'd2;
                        state            <= S_B_HI;
                    end
                end

                S_B_HI: begin
                    if (accept) begin
                        op_b[OP_W-1:DATA_W] <= bus.DATA_IN;
                        word_idx            <= 2'd3;
                        state               <= S_B_LO;
                    end
                end

                S_B_LO: begin
                    if (accept) begin
                        op_b[DATA_W-1:0] <= bus.DATA_IN;
                        busy             <= 1'b1;
                        state            <= S_CHECK;
                    end
                end

                // Operands are complete in the registers here, so the check
                // sees the word just written in B_LO.
                S_CHECK: begin
                    if (a_bad || b_bad) begin
                        err   <= {b_bad, a_bad};
                        busy  <= 1'b0;
                        state <= S_ERROR;
                    end else begin
                        op_valid <= 1'b1;
                        state    <= S_VALID;
                    end
                end

                S_VALID: begin
                    if (bus.OP_ACK) begin
                        op_valid <= 1'b0;
                        busy     <= 1'b0;
                        word_idx <= 2'd0;
                        state    <= S_A_HI;
                    end
                end

                // Sticky until reset; the error LEDs keep showing the cause.
                S_ERROR: begin
                    state <= S_ERROR;
                end

                default: begin
                    state <= S_A_HI;
                end
            endcase
        end
    end

    assign bus.OP_A     = op_a;
    assign bus.OP_B     = op_b;
    assign bus.OP_VALID = op_valid;
    assign bus.WORD_IDX = word_idx;
    assign bus.BUSY     = busy;
    assign bus.ERR      = err;
endmodule
